dist_line_copier: RTL and testbench

- Initiator-side engine that copies a run of 256-bit distribution lines from a source region to a destination region of data memory.
- Drives the data memory's line-read (DMemRead) and line-write (DMemWrite) request interface and paces itself on the memory's clk_stall handshake.
- Sits beside the core's load/store path. The core arms it with start, and the arbiter grants it the memory port while busy=1.

---
 rtl/dist_line_copier.sv | 147 ++++++++++++++
 tb/tb_dist_line_copier.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_line_copier.sv
// Line-copy engine: streams 256-bit lines from a source to a destination
// region through the data-memory read/write port, paced by mem_stall.
module dist_line_copier #(
  parameter int LINE_BYTES = 32,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] line_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_dread,
  output logic             mem_dwrite,
  output logic [255:0]     mem_wline,
  input  logic [255:0]     mem_rline,
  input  logic             mem_stall
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        src_cur, dst_cur;
  logic [CNT_W-1:0]   remaining;
  logic [255:0]       line_q;
  logic               seen;
  logic [TW-1:0]      wcnt;
  logic               err_q;
  logic               in_wait;
  logic               wait_exit;
  logic               wait_tmo;
  logic               accept;

  assign accept    = (state == IDLE) && start;
  assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
  assign wait_exit = in_wait && seen && !mem_stall;
  // Give up once the memory has stalled us for TIMEOUT wait cycles.
  assign wait_tmo  = in_wait && !wait_exit
                     && (wcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (line_count == '0) ? FIN : RD_REQ;
      end
      RD_REQ: state_nx = RD_WAIT;
      RD_WAIT: begin
        if (wait_exit)     state_nx = WR_REQ;
        else if (wait_tmo) state_nx = FIN;
      end
      WR_REQ: state_nx = WR_WAIT;
      WR_WAIT: begin
        if (wait_exit)
          state_nx = (remaining == CNT_W'(1)) ? FIN : RD_REQ;
        else if (wait_tmo)
          state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_dread  = 1'b0;
    mem_dwrite = 1'b0;
    mem_addr   = '0;
    unique case (state)
      IDLE: ;
      RD_REQ: begin
        busy      = 1'b1;
        mem_dread = 1'b1;
        mem_addr  = src_cur;
      end
      RD_WAIT: busy = 1'b1;
      WR_REQ: begin
        busy       = 1'b1;
        mem_dwrite = 1'b1;
        mem_addr   = dst_cur;
      end
      WR_WAIT: busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign mem_wline = line_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      line_q    <= '0;
      seen      <= 1'b0;
      wcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        src_cur   <= {src_addr[31:5], 5'b0};
        dst_cur   <= {dst_addr[31:5], 5'b0};
        remaining <= line_count;
        err_q     <= 1'b0;
      end
      if ((state == RD_REQ) || (state == WR_REQ)) begin
        seen <= 1'b0;
        wcnt <= '0;
      end else if (in_wait) begin
        if (mem_stall) seen <= 1'b1;
        wcnt <= wcnt + TW'(1);
      end
      if ((state == RD_WAIT) && wait_exit)
        line_q <= mem_rline;
      if ((state == WR_WAIT) && wait_exit) begin
        src_cur   <= src_cur + 32'(LINE_BYTES);
        dst_cur   <= dst_cur + 32'(LINE_BYTES);
        remaining <= remaining - CNT_W'(1);
      end
      if (wait_tmo)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dist_line_copier.sv
// Bench for dist_line_copier: behavioural stalling memory plus a
// request scoreboard checked on every issued memory access.
module tb_dist_line_copier;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  src_addr = '0;
  logic [31:0]  dst_addr = '0;
  logic [7:0]   line_count = '0;
  logic         busy, done, err;
  logic [31:0]  mem_addr;
  logic         mem_dread, mem_dwrite;
  logic [255:0] mem_wline;
  logic [255:0] mem_rline = '0;
  logic         mem_stall = 1'b0;

  dist_line_copier dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .line_count (line_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_dread  (mem_dread),
    .mem_dwrite (mem_dwrite),
    .mem_wline  (mem_wline),
    .mem_rline  (mem_rline),
    .mem_stall  (mem_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  always @(posedge clk) cyc++;

  // memory model
  logic [255:0] mem [bit [31:0]];
  int           hold = 2;
  bit           stuck = 1'b0;
  int           mcnt = 0;
  bit           mbusy = 1'b0;
  logic [255:0] mpend = '0;

  always @(posedge clk) begin
    if (mbusy) begin
      if (!stuck) begin
        if (mcnt <= 1) begin
          mem_stall <= 1'b0;
          mem_rline <= mpend;
          mbusy = 1'b0;
        end else begin
          mcnt--;
        end
      end
    end else if (mem_dread || mem_dwrite) begin
      mbusy = 1'b1;
      mcnt = hold;
      mem_stall <= 1'b1;
      if (mem_dread)
        mpend = mem.exists(mem_addr) ? mem[mem_addr] : '0;
      else
        mem[mem_addr] = mem_wline;
    end
  end

  // request scoreboard
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } req_t;

  req_t exp_q[$];
  req_t mon_e;
  bit   prev_req = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_dread || mem_dwrite) begin
        checks++;
        if (prev_req) begin
          errors++;
          $display("FAIL req_width: request held at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: rd=%b wr=%b addr=%h, none expected",
                   mem_dread, mem_dwrite, mem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if ((mon_e.wr !== mem_dwrite) || (mem_dread === mem_dwrite)
              || (mon_e.addr !== mem_addr)
              || (mon_e.wr && (mon_e.data !== mem_wline))) begin
            errors++;
            $display("FAIL req: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                     mem_dwrite, mem_addr, mem_wline,
                     mon_e.wr, mon_e.addr, mon_e.data);
          end
        end
      end
      prev_req = mem_dread || mem_dwrite;
    end else begin
      prev_req = 1'b0;
    end
  end

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic push_line(input logic [31:0] s, input logic [31:0] d);
    req_t r;
    r.wr = 1'b0; r.addr = s; r.data = '0;
    exp_q.push_back(r);
    r.wr = 1'b1; r.addr = d;
    r.data = mem.exists(s) ? mem[s] : '0;
    exp_q.push_back(r);
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input int n, input bit push);
    logic [31:0] sa, da;
    sa = {s[31:5], 5'b0};
    da = {d[31:5], 5'b0};
    if (push)
      for (int i = 0; i < n; i++)
        push_line(sa + 32'(32 * i), da + 32'(32 * i));
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    line_count = 8'(n);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc,
                           input int budget);
    bit got = 1'b0;
    int rel = 0;
    for (int k = 0; k < budget && !got; k++) begin
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    rel = cyc - c0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", nm, budget);
    end else if (exp_cyc >= 0 && rel != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d want %0d", nm, rel, exp_cyc);
    end
    checks++;
    if (got && busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b want 0", nm, busy);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_req: %0d requests never issued", nm,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_line(input string nm, input logic [31:0] a,
                            input logic [255:0] want);
    logic [255:0] got;
    got = mem.exists(a) ? mem[a] : 'x;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_data@%h: got %h want %h", nm, a, got, want);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, err, mem_dread, mem_dwrite} !== 5'b0
        || mem_addr !== '0 || mem_wline !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b rd=%b wr=%b addr=%h",
               busy, done, err, mem_dread, mem_dwrite, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    mem[32'h40] = {32{8'hA5}};
    launch(32'h40, 32'h100, 1, 1'b1);
    wait_done("single", 9, 50);
    check_line("single", 32'h100, {32{8'hA5}});
  endtask

  task automatic test_burst();
    for (int i = 0; i < 3; i++) mem[32'h20 + 32'(32 * i)] = pat(i + 1);
    launch(32'h20, 32'h1E0, 3, 1'b1);
    wait_done("burst", 25, 100);
    for (int i = 0; i < 3; i++)
      check_line("burst", 32'h1E0 + 32'(32 * i), pat(i + 1));
  endtask

  task automatic test_unaligned_zero();
    mem[32'h40] = pat(7);
    launch(32'h47, 32'h305, 1, 1'b1);
    wait_done("unaligned", 9, 50);
    check_line("unaligned", 32'h300, pat(7));
    launch(32'h500, 32'h600, 0, 1'b1);
    wait_done("zero", 1, 20);
  endtask

  task automatic test_ignored_start();
    mem[32'h800] = pat(20);
    mem[32'h820] = pat(21);
    launch(32'h800, 32'h900, 2, 1'b1);
    @(negedge clk);
    src_addr = 32'hA00;
    dst_addr = 32'hB00;
    line_count = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored", 17, 100);
    check_line("ignored", 32'h900, pat(20));
    check_line("ignored", 32'h920, pat(21));
  endtask

  task automatic test_slow_mem();
    hold = 10;
    mem[32'hC00] = pat(30);
    mem[32'hC20] = pat(31);
    launch(32'hC00, 32'hD00, 2, 1'b1);
    wait_done("slow", -1, 200);
    check_line("slow", 32'hD00, pat(30));
    check_line("slow", 32'hD20, pat(31));
    hold = 2;
  endtask

  task automatic test_timeout();
    req_t r;
    stuck = 1'b1;
    mem[32'hE00] = pat(40);
    r.wr = 1'b0; r.addr = 32'hE00; r.data = '0;
    exp_q.push_back(r);
    launch(32'hE00, 32'hF00, 2, 1'b0);
    wait_done("timeout", -1, 600);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err: got %b want 1", err);
    end
    stuck = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    mem[32'hE20] = pat(41);
    launch(32'hE20, 32'hF20, 1, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    wait_done("after_err", 9, 50);
    check_line("after_err", 32'hF20, pat(41));
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(32 * i)] = pat(50 + i);
    launch(32'h1000, 32'h2000, 4, 1'b1);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_dread, mem_dwrite} !== 5'b0
        || mem_addr !== '0 || mem_wline !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b rd=%b wr=%b addr=%h",
               busy, done, mem_dread, mem_dwrite, mem_addr);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    mem[32'h3000] = pat(60);
    launch(32'h3000, 32'h3100, 1, 1'b1);
    wait_done("post_reset", 9, 50);
    check_line("post_reset", 32'h3100, pat(60));
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_unaligned_zero();
    test_ignored_start();
    test_slow_mem();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
